// File: rtl/clk_mon_pkg.sv
// Shared types and default settings for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    MEAS = 2'd2,
    LOCK = 2'd3
  } mon_state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PERIOD_MIN  = 3;
  localparam int DEF_PERIOD_MAX  = 3;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus rise/fall detection
// against a one-cycle history of the synchronized level.
module sync_edge_det
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a generated clock sampled on its reference
// clock, and reports lock, out-of-window and missing-edge status.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX  = DEF_PERIOD_MAX,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_range,
  output logic             err_timeout
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  P_MIN      = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0]  P_MAX      = CNT_W'(PERIOD_MAX);
  localparam logic [GOOD_W-1:0] LOCK_N     = GOOD_W'(LOCK_COUNT);

  mon_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_inc, hi_cap;
  logic [GOOD_W-1:0] good_cnt, good_inc;
  logic              mon_level_unused, rise, fall;
  logic              active, pub, in_range, timeout_ev, range_ev;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (mon_in),
    .level   (mon_level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign good_inc   = (good_cnt == LOCK_N) ? good_cnt : good_cnt + 1'b1;
  assign active     = en && ((state == MEAS) || (state == LOCK));
  assign pub        = active && rise;
  assign in_range   = (cnt_inc >= P_MIN) && (cnt_inc <= P_MAX);
  assign range_ev   = pub && !in_range;
  // cnt would reach TIMEOUT at this edge without a rise closing the period
  assign timeout_ev = active && !rise && (cnt == TIMEOUT_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (en) state_n = ACQ;
      ACQ:  if (rise) state_n = MEAS;
      MEAS, LOCK: begin
        if (pub) begin
          if (!in_range)               state_n = MEAS;
          else if (good_inc == LOCK_N) state_n = LOCK;
        end else if (timeout_ev) begin
          state_n = ACQ;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!en) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      hi_cap      <= '0;
      good_cnt    <= '0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      meas_valid  <= pub;
      err_range   <= range_ev | (err_range & ~clr_err);
      err_timeout <= timeout_ev | (err_timeout & ~clr_err);
      if (!en) begin
        cnt      <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        cnt <= rise ? '0 : cnt_inc;
        // the fall cycle's count lags the number of high cycles by one
        if (fall) hi_cap <= cnt_inc;
        if (pub) begin
          period    <= cnt_inc;
          high_time <= hi_cap;
          if (in_range) begin
            good_cnt <= good_inc;
            if (good_inc == LOCK_N) locked <= 1'b1;
          end else begin
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end else if (timeout_ev) begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock acquisition, range errors, sticky
// clear priority, timeout, enable drop and asynchronous reset.
module tb_clk_div_monitor;

  logic        clk = 1'b0;
  logic        rst, en, mon_in, clr_err;
  logic [15:0] period, high_time;
  logic        meas_valid, locked, err_range, err_timeout;

  int checks = 0;
  int errors = 0;
  int mve;
  int mvcnt;

  clk_div_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mon_in      (mon_in),
    .clr_err     (clr_err),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err_range   (err_range),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic m);
    mon_in = m;
    @(posedge clk);
    #1;
  endtask

  // One mon_in period: hi cycles high then lo cycles low; clr_err on the last cycle if asked.
  // Counts meas_valid pulses seen before the last cycle.
  task automatic grp(input int hi, input int lo, input logic clr_last, output int mv_early);
    mv_early = 0;
    for (int i = 0; i < hi + lo; i++) begin
      clr_err = clr_last && (i == hi + lo - 1);
      tick(i < hi);
      clr_err = 1'b0;
      if ((i < hi + lo - 1) && meas_valid) mv_early++;
    end
  endtask

  task automatic chk_grp(input string tag, input int mve_got, input int mve_exp,
                         input logic mv_exp, input logic [15:0] per_exp,
                         input logic lk_exp, input logic er_exp, input logic et_exp);
    chk({tag, "_early_mv"}, mve_got, mve_exp);
    chk({tag, "_meas_valid"}, meas_valid, mv_exp);
    chk({tag, "_locked"}, locked, lk_exp);
    chk({tag, "_err_range"}, err_range, er_exp);
    chk({tag, "_err_timeout"}, err_timeout, et_exp);
    if (mv_exp) begin
      chk({tag, "_period"}, period, per_exp);
      chk({tag, "_high_time"}, high_time, 16'd2);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_time"}, high_time, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_range"}, err_range, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mon_in = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");

    rst = 1'b0;
    en  = 1'b1;
    repeat (3) tick(1'b0);

    // acquisition: first publish on the 2nd rise, lock on the 4th publish
    for (int g = 0; g < 6; g++) begin
      grp(2, 1, 1'b0, mve);
      chk_grp("acq", mve, 0, g >= 1, 16'd3, g >= 4, 1'b0, 1'b0);
    end

    // one stretched period of 5
    grp(2, 3, 1'b0, mve);
    chk_grp("stretch_pre", mve, 1, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0);
    grp(2, 1, 1'b0, mve);
    chk_grp("stretch_meas", mve, 0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      grp(2, 1, 1'b0, mve);
      chk_grp("relock", mve, 0, 1'b1, 16'd3, g == 3, 1'b1, 1'b0);
    end

    // clr_err coinciding with a new range error: set wins
    grp(2, 3, 1'b0, mve);
    chk_grp("stretch2_pre", mve, 1, 1'b0, 16'd3, 1'b1, 1'b1, 1'b0);
    grp(2, 1, 1'b1, mve);
    chk_grp("clr_vs_set", mve, 0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0);
    grp(2, 1, 1'b0, mve);
    chk_grp("err_sticky", mve, 0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0);
    grp(2, 1, 1'b1, mve);
    chk_grp("clr_alone", mve, 0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      grp(2, 1, 1'b0, mve);
      chk_grp("relock2", mve, 0, 1'b1, 16'd3, g == 1, 1'b0, 1'b0);
    end

    // mon_in stuck low: timeout 64 cycles after the last rise cycle
    mvcnt = 0;
    for (int i = 0; i < 63; i++) begin
      tick(1'b0);
      if (meas_valid) mvcnt++;
    end
    chk("to_before_flag", err_timeout, 0);
    chk("to_before_locked", locked, 1);
    chk("to_no_meas", mvcnt, 0);
    tick(1'b0);
    chk("to_flag", err_timeout, 1);
    chk("to_locked", locked, 0);
    chk("to_meas_valid", meas_valid, 0);

    grp(2, 1, 1'b0, mve);
    chk_grp("restart_first", mve, 0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
    grp(2, 1, 1'b0, mve);
    chk_grp("restart_meas", mve, 0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1);
    grp(2, 1, 1'b1, mve);
    chk_grp("clr_timeout", mve, 0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      grp(2, 1, 1'b0, mve);
      chk_grp("relock3", mve, 0, 1'b1, 16'd3, g == 1, 1'b0, 1'b0);
    end

    // enable dropped while locked
    en = 1'b0;
    tick(1'b1);
    chk("en_off_locked", locked, 0);
    chk("en_off_period", period, 3);
    chk("en_off_high", high_time, 2);
    tick(1'b1);
    tick(1'b0);
    chk("en_off_meas_valid", meas_valid, 0);
    grp(2, 1, 1'b0, mve);
    chk_grp("en_off_grp", mve, 0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0);
    chk("en_off_hold_period", period, 3);
    en = 1'b1;
    grp(2, 1, 1'b0, mve);
    chk_grp("en_acq", mve, 0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0);
    grp(2, 1, 1'b0, mve);
    chk_grp("en_meas", mve, 0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-period
    tick(1'b1);
    #2;
    rst    = 1'b1;
    mon_in = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #3;
    rst = 1'b0;
    repeat (3) tick(1'b0);
    for (int g = 0; g < 5; g++) begin
      grp(2, 1, 1'b0, mve);
      chk_grp("post_rst", mve, 0, g >= 1, 16'd3, g >= 4, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
